// File: rtl/risc_pkg.sv
// Shared definitions for the output trace path.
//   DATA_W             width of the processor `out` bus
//   CNT_W              width of the cycle-delta timestamp
//   trace_st_e         trace FSM state encoding
//   ENT_*              bit offsets of the fields in a trace entry {delta, value}
package risc_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACING = 2'd2
  } trace_st_e;

  localparam int ENT_VAL_LSB = 0;
  localparam int ENT_DLT_LSB = DATA_W;
  localparam int ENT_W       = CNT_W + DATA_W;
endpackage

// File: rtl/out_trace_buffer_if.sv
// Valid/ready drain port carrying trace entries to the host monitor.
//   m_valid  head entry available (master drives)
//   m_ready  host accepts head entry (slave drives)
//   m_data   {delta, value} of head entry (master drives)
interface out_trace_buffer_if
  import risc_pkg::*;
#(
  parameter int W = risc_pkg::ENT_W
);
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for trace entries.
//   clk, reset  clock; async active-low reset
//   flush       synchronous clear; wins over a same-cycle push/pop
//   push, din   write request and data; accepted when not full, or when full
//               and a pop happens on the same edge
//   pop         read request; ignored when empty
//   dout        head entry, zero when empty
//   full, empty, level   occupancy status, level is the true count 0..DEPTH
module trace_fifo
  import risc_pkg::*;
#(
  parameter int WIDTH = risc_pkg::ENT_W,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one written, so a same-edge
  // push/pop keeps the count at DEPTH.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

  assign dout = empty ? '0 : mem[rptr];
endmodule

// File: rtl/out_trace_buffer.sv
// Records every change of the processor `out` bus as a {delta_cycles, value}
// entry and drains the entries to a host monitor over a valid/ready port.
//   clk, reset  clock; async active-low reset
//   en          trace enable
//   flush       one-cycle FIFO clear (FSM, prev and drop_cnt keep their state)
//   out_in      processor `out` bus, sampled every cycle
//   m           drain port (m_valid / m_ready / m_data)
//   level       FIFO occupancy
//   drop_cnt    captures lost to a full FIFO, saturating
module out_trace_buffer
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int CNT_W  = risc_pkg::CNT_W,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      out_in,
  out_trace_buffer_if.master     m,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt
);
  trace_st_e          st, st_nxt;
  logic               cap;
  logic [DATA_W-1:0]  prev;
  logic [CNT_W-1:0]   delta;
  logic [CNT_W-1:0]   dlt_ent;
  logic               full, empty, pop_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    cap    = 1'b0;
    case (st)
      IDLE:    if (en) st_nxt = ARMED;
      ARMED: begin
        if (en) begin
          cap    = 1'b1;
          st_nxt = TRACING;
        end else begin
          st_nxt = IDLE;
        end
      end
      TRACING: begin
        if (!en) st_nxt = IDLE;
        else     cap = (out_in != prev);
      end
      default: st_nxt = IDLE;
    endcase
  end

  // The first capture after arming anchors the trace with a zero delta.
  assign dlt_ent = (st == ARMED) ? '0 : delta;
  assign pop_req = m.m_valid && m.m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev     <= '0;
      delta    <= '0;
      drop_cnt <= '0;
    end else begin
      if (cap) prev <= out_in;

      if (cap)                          delta <= CNT_W'(1);
      else if (st != TRACING || !en)    delta <= '0;
      else if (delta != {CNT_W{1'b1}})  delta <= delta + 1'b1;

      if (cap && full && !pop_req && drop_cnt != {DROP_W{1'b1}})
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  trace_fifo #(.WIDTH(CNT_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (cap),
    .din   ({dlt_ent, out_in}),
    .full  (full),
    .pop   (m.m_ready),
    .dout  (m.m_data),
    .empty (empty),
    .level (level)
  );

  assign m.m_valid = !empty;
endmodule

// File: tb/tb_out_trace_buffer.sv
module tb_out_trace_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out_in = '0;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  out_trace_buffer_if bus ();

  out_trace_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .out_in   (out_in),
    .m        (bus.master),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ent(input logic [15:0] d, input logic [31:0] v);
    return {16'd0, d, v};
  endfunction

  initial begin
    bus.m_ready = 1'b0;
    #3;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst_data",  bus.m_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: three captures, delta counted in edges between captures
    bus.m_ready = 1'b1;
    en = 1'b1;
    step();                                  // IDLE -> ARMED
    step();                                  // t0: ARMED capture {0,0}
    chk("t1_v0", bus.m_valid, 1);
    chk("t1_e0", bus.m_data, ent(0, 0));
    step();                                  // t0+1: popped
    chk("t1_pop0", bus.m_valid, 0);
    step();                                  // t0+2
    out_in = 5;
    step();                                  // t0+3 capture
    chk("t1_e1", bus.m_data, ent(3, 5));
    step(); step(); step();                  // t0+4..t0+6
    out_in = 9;
    step();                                  // t0+7 capture
    chk("t1_e2", bus.m_data, ent(4, 9));
    step();
    chk("t1_empty", level, 0);

    // 2: 20 captures into a 16-deep FIFO with no drain
    bus.m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      out_in = 100 + i;
      step();
    end
    chk("t2_level", level, 16);
    chk("t2_drop",  drop_cnt, 4);
    chk("t2_head",  bus.m_data, ent(2, 100));

    // 3: capture while full with a same-cycle pop
    bus.m_ready = 1'b1;
    out_in = 200;
    step();
    chk("t3_level", level, 16);
    chk("t3_drop",  drop_cnt, 4);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t2_drain%0d", i), bus.m_data, ent(1, 100 + i));
      step();
    end
    chk("t3_tail", bus.m_data, ent(1, 200));
    step();
    chk("t3_empty", bus.m_valid, 0);

    // 4: long idle stretch saturates the delta field
    bus.m_ready = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    out_in = 201;
    step();
    chk("t4_sat", bus.m_data, ent(16'hffff, 201));

    // 5: held head stays stable, then flush beats a capture
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_hold%0d", i), bus.m_data, ent(16'hffff, 201));
    end
    chk("t5_valid", bus.m_valid, 1);
    flush = 1'b1;
    out_in = 202;
    step();
    flush = 1'b0;
    chk("t5_fl_valid", bus.m_valid, 0);
    chk("t5_fl_level", level, 0);
    chk("t5_fl_drop",  drop_cnt, 4);
    out_in = 203;
    step();
    chk("t5_after", bus.m_data, ent(1, 203));

    // 6: async reset mid-cycle with three entries queued
    out_in = 204; step();
    out_in = 205; step();
    chk("t6_level3", level, 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", bus.m_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_data",  bus.m_data, 0);
    chk("t6_rst_drop",  drop_cnt, 0);
    #3 reset = 1'b1;
    out_in = 77;
    step();                                  // IDLE -> ARMED
    chk("t6_armed_empty", bus.m_valid, 0);
    step();                                  // ARMED capture
    chk("t6_cap", bus.m_data, ent(0, 77));
    chk("t6_cap_level", level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
